// File: rtl/uart_tx_serializer_if.sv
// +----------------------------------------------------------------------+
// | uart_tx_serializer_if : byte request/response handshake for the TX   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// +----------------------------------------------------------------------+
// | uart_tx_serializer : baud-enabled UART frame shifter (start/data/    |
// | optional parity/stop), all outputs registered. Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_serializer #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     baud_tick,
  uart_tx_serializer_if.slave      bus,
  output logic                     tx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [3:0] C_DATA_BITS = 4'(DATA_BITS);
  localparam logic [1:0] C_STOP_BITS = 2'(STOP_BITS);

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_cnt;
  logic [1:0]           r_stop_cnt;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_parity;

  generate
    if (PARITY_MODE == 2) begin : g_parity_odd
      assign w_parity = ~(^bus.tx_data);
    end else begin : g_parity_even
      assign w_parity = ^bus.tx_data;
    end
  endgenerate

  // tx resets straight to its idle level, so an abort never drives a low glitch
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (bus.tx_start) begin
            r_shift   <= bus.tx_data;
            r_parity  <= w_parity;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_ARM;
          end
        end
        S_ARM: begin
          if (baud_tick) begin
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= 4'd1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (r_bit_cnt < C_DATA_BITS) begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (PARITY_MODE != 0) begin
              r_tx    <= r_parity;
              r_state <= S_PARITY;
            end else begin
              r_tx       <= 1'b1;
              r_stop_cnt <= 2'd1;
              r_state    <= S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            r_tx       <= 1'b1;
            r_stop_cnt <= 2'd1;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (r_stop_cnt < C_STOP_BITS) begin
              r_stop_cnt <= r_stop_cnt + 2'd1;
            end else begin
              r_stop_cnt <= '0;
              r_bit_cnt  <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx          = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;

endmodule

`default_nettype wire
